fnd_scan_ctrl: RTL and testbench
================================

Name: fnd_scan_ctrl

Overview:
- Time-multiplexing scan controller for the Basys3 4-digit 7-segment display.
- Generates the 3-bit slot select that drives the 8-to-1 digit mux, the matching active-low anode enables, and the blinking dot code the mux presents in slot 6.
- Sits directly upstream of the digit mux and in parallel with the BCD-to-segment decoder, which consumes the same slot timing.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- SCAN_HZ, 8_000, slot-advance rate in Hz. 8 slots gives a 1 kHz full-frame refresh.
- DOT_HZ, 2, dot blink rate in Hz. One full on+off period per 1/DOT_HZ s.

Ports:
- clk, input, 1, system clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- scan_en, input, 1, 1 = scanning runs; 0 = prescaler and slot counter hold, anodes forced off.
- blink_en, input, 1, 1 = dot toggles at DOT_HZ; 0 = dot held on.
- sel, output, 3, slot index to the digit mux.
- an, output, 4, anode enables, active low. an[0] = ones digit … an[3] = thousands digit.
- dot_signal, output, 4, dot code to the mux. 4'hE = dot lit, 4'hF = blank.
- scan_tick, output, 1, one-cycle pulse on every slot advance.

Behaviour:
- Reset (reset_n low, asynchronous) sets:
  - sel=3'd0, an=4'b1111, dot_signal=4'hF, scan_tick=0.
  - Prescaler, blink counter and blink phase = 0.
- Reset release is synchronous to clk. The first tick occurs SCAN_DIV cycles after release.
- Divider constants:
  - SCAN_DIV = CLK_FREQ/SCAN_HZ, integer division, must be ≥ 2.
  - BLINK_DIV = CLK_FREQ/(2*DOT_HZ).
  - Counter widths = $clog2 of each divider.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 while scan_en=1, then wraps to 0.
  - scan_tick=1 in the cycle the count equals SCAN_DIV-1.
- Slot counter:
  - On scan_tick, sel increments modulo 8 (7→0 wrap).
  - sel is registered and changes the cycle after scan_tick is asserted.
- Anodes are registered, derived from the next sel value so they align with sel (zero skew):
  - sel 0..3 → an drives that digit low (0→4'b1110, 1→4'b1101, 2→4'b1011, 3→4'b0111).
  - sel 6 → 4'b1011 (dot shown at the hundreds position, seconds/centiseconds separator).
  - sel 4, 5, 7 → 4'b1111 (blank slots; the mux outputs 4'hF there).
- scan_en=0:
  - Prescaler and sel hold their values; an=4'b1111 from the next cycle; scan_tick=0.
  - On re-enable, counting resumes from the held prescaler value.
- Blink:
  - Independent free-running counter, 0..BLINK_DIV-1. Not gated by scan_en.
  - phase toggles on its wrap.
  - dot_signal = 4'hE when (blink_en=0 or phase=1), else 4'hF.
  - dot_signal is registered; it updates only on the cycle scan_tick fires, so it never changes mid-slot.
- Simultaneous events:
  - Blink wrap coinciding with scan_tick: the new phase is used in the same update.
  - blink_en toggling mid-slot: takes effect at the next scan_tick.
- Mid-operation reset forces all outputs to their reset values immediately, regardless of slot.

Optional Feature:
- Macro: FND_DIM_EN.
- Defined:
  - Adds input dim_level[1:0].
  - The anode pattern is gated within each slot. Active anode(s) are driven only while prescaler < (dim_level+1)*SCAN_DIV/4, otherwise an=4'b1111.
  - dim_level=3 gives full brightness; dim_level=0 gives 25 %.
- Not defined: the port is absent and anodes stay active for the whole slot.

Decomposition:
- Shared package fnd_pkg holds:
  - Slot constants SLOT_D1=0, SLOT_D10=1, SLOT_D100=2, SLOT_D1000=3, SLOT_DOT=6.
  - Codes BCD_BLANK=4'hF, BCD_DOT=4'hE.
  - Anode patterns AN_OFF=4'b1111 and the per-slot one-hot-low values.
- One sub-module, tick_gen (parameter DIV, ports clk, reset_n, en, tick). It is instantiated twice: scan prescaler (en=scan_en) and blink timer (en=1).

Test Plan (sim with CLK_FREQ=1000, SCAN_HZ=100, DOT_HZ=10 → SCAN_DIV=10, BLINK_DIV=50):
- Reset: hold reset_n=0 for 5 cycles with scan_en=1 → sel=0, an=4'b1111, dot_signal=4'hF, scan_tick=0. After release, first scan_tick on cycle 10 and sel=1 on cycle 11.
- Full rotation: run 80 cycles → sel sequence 0..7 then 0. an sequence 1110, 1101, 1011, 0111, 1111, 1111, 1011, 1111; exactly 8 scan_tick pulses.
- Hold: drop scan_en for 25 cycles in slot 2 → sel stays 2, an=4'b1111 after 1 cycle, no scan_tick. Re-assert → slot 2 resumes with remaining prescaler count.
- Blink: blink_en=1, observe 200 cycles → dot_signal alternates 4'hE/4'hF every 50 cycles, changes only on scan_tick cycles. blink_en=0 → dot_signal=4'hE at the next tick.
- Async reset mid-slot: assert reset_n=0 between clock edges while sel=6 → all outputs return to reset values without waiting for a clk edge.
- FND_DIM_EN with dim_level=1: in slot 0, an=4'b1110 for prescaler 0..4 and 4'b1111 for 5..9. With dim_level=3, an=4'b1110 for the whole slot.

Source files
------------

// File: rtl/fnd_pkg.sv
// ---------------------------------------------------------------------------
// fnd_pkg
// Shared constants for the Basys3 4-digit 7-segment display path.
//   - Slot indices used by the 8-to-1 digit mux and the scan controller.
//   - BCD codes the mux presents for a lit dot and for a blank digit.
//   - Active-low anode patterns, one per visible digit position, plus AN_OFF.
//   - slot_anode(): maps a slot index to its anode pattern.
// ---------------------------------------------------------------------------
package fnd_pkg;

    localparam logic [2:0] SLOT_D1    = 3'd0;
    localparam logic [2:0] SLOT_D10   = 3'd1;
    localparam logic [2:0] SLOT_D100  = 3'd2;
    localparam logic [2:0] SLOT_D1000 = 3'd3;
    localparam logic [2:0] SLOT_DOT   = 3'd6;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam logic [3:0] BCD_DOT    = 4'hE;

    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam logic [3:0] AN_D1      = 4'b1110;
    localparam logic [3:0] AN_D10     = 4'b1101;
    localparam logic [3:0] AN_D100    = 4'b1011;
    localparam logic [3:0] AN_D1000   = 4'b0111;

    // The dot slot lights the hundreds position so the dot lands between
    // the seconds and centiseconds digits. Slots 4, 5 and 7 are blank.
    function automatic logic [3:0] slot_anode(input logic [2:0] slot);
        logic [3:0] pattern;
        case (slot)
            SLOT_D1:    pattern = AN_D1;
            SLOT_D10:   pattern = AN_D10;
            SLOT_D100:  pattern = AN_D100;
            SLOT_D1000: pattern = AN_D1000;
            SLOT_DOT:   pattern = AN_D100;
            default:    pattern = AN_OFF;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Enable-gated modulo-DIV counter producing a one-cycle tick on its last count.
// Parameters:
//   DIV        - division ratio, must be >= 2.
// Ports:
//   clk        - system clock, rising edge.
//   reset_n    - asynchronous active-low reset, counter cleared to 0.
//   en         - 1 = count, 0 = hold the current count (tick forced low).
//   tick       - high in the cycle the count equals DIV-1 while en=1.
//   count_next - value the counter takes at the next clock edge; lets a
//                consumer register outputs aligned with the count.
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter  int DIV = 10,
    localparam int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    output logic         tick,
    output logic [W-1:0] count_next
);

    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    assign count_next = cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// fnd_scan_ctrl
// Time-multiplexing scan controller for the Basys3 4-digit 7-segment display.
// Drives the slot select of the 8-to-1 digit mux, the matching active-low
// anode enables and the blinking dot code shown in the dot slot.
//
// Parameters:
//   CLK_FREQ   - system clock in Hz.
//   SCAN_HZ    - slot-advance rate in Hz (8 slots per frame).
//   DOT_HZ     - full on+off blink rate of the dot in Hz.
// Ports:
//   clk        - system clock, rising edge.
//   reset_n    - asynchronous active-low reset.
//   scan_en    - 1 = scanning runs; 0 = prescaler/slot hold, anodes off.
//   blink_en   - 1 = dot blinks at DOT_HZ; 0 = dot held on.
//   dim_level  - (FND_DIM_EN only) brightness, 0 = 25 % .. 3 = 100 %.
//   sel        - slot index to the digit mux.
//   an         - anode enables, active low, an[0] = ones digit.
//   dot_signal - dot code to the mux: BCD_DOT lit, BCD_BLANK dark.
//   scan_tick  - one-cycle pulse on every slot advance.
//
// Build option: define FND_DIM_EN to add dim_level and gate the anodes to the
// first (dim_level+1)/4 of every slot. Without it the anodes stay active for
// the whole slot.
// ---------------------------------------------------------------------------
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 8_000,
    parameter int DOT_HZ   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scan_en,
    input  logic       blink_en,
`ifdef FND_DIM_EN
    input  logic [1:0] dim_level,
`endif
    output logic [2:0] sel,
    output logic [3:0] an,
    output logic [3:0] dot_signal,
    output logic       scan_tick
);

    // SCAN_DIV must come out >= 2 for the prescaler to produce single-cycle ticks.
    localparam int SCAN_DIV  = CLK_FREQ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_FREQ / (2 * DOT_HZ);
    localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic       blink_tick;
    logic [2:0] sel_q,   sel_d;
    logic [3:0] an_q,    an_d;
    logic [3:0] dot_q,   dot_d;
    logic       phase_q, phase_d;

    // ---------------------------------------------------------------------
    // Scan prescaler and blink timer
    // ---------------------------------------------------------------------
`ifdef FND_DIM_EN
    logic [SCAN_W-1:0] scan_cnt_next;
    logic [31:0]       dim_thr;

    tick_gen #(.DIV(SCAN_DIV)) u_scan_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (scan_en),
        .tick       (scan_tick),
        .count_next (scan_cnt_next)
    );
`else
    tick_gen #(.DIV(SCAN_DIV)) u_scan_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (scan_en),
        .tick       (scan_tick),
        .count_next ()
    );
`endif

    // Free-running: the blink cadence must not stall when scanning is paused.
    tick_gen #(.DIV(BLINK_DIV)) u_blink_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (1'b1),
        .tick       (blink_tick),
        .count_next ()
    );

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // 3-bit increment wraps 7 -> 0 on its own.
    assign sel_d   = scan_tick ? sel_q + 3'd1 : sel_q;
    assign phase_d = blink_tick ? ~phase_q : phase_q;

`ifdef FND_DIM_EN
    // Anodes are registered from the next prescaler value so the on-window
    // lines up with the prescaler count seen in the same cycle.
    assign dim_thr = ((32'(dim_level) + 32'd1) * 32'(SCAN_DIV)) / 32'd4;

    always_comb begin
        an_d = AN_OFF;
        if (scan_en && (32'(scan_cnt_next) < dim_thr)) begin
            an_d = slot_anode(sel_d);
        end
    end
`else
    // Registered from the next slot so an and sel switch on the same edge.
    always_comb begin
        an_d = AN_OFF;
        if (scan_en) begin
            an_d = slot_anode(sel_d);
        end
    end
`endif

    // Sampled only on a slot advance so the dot never flips mid-slot; using
    // phase_d lets a blink wrap on the same edge take effect immediately.
    always_comb begin
        dot_d = dot_q;
        if (scan_tick) begin
            dot_d = (!blink_en || phase_d) ? BCD_DOT : BCD_BLANK;
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q   <= SLOT_D1;
            an_q    <= AN_OFF;
            dot_q   <= BCD_BLANK;
            phase_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            an_q    <= an_d;
            dot_q   <= dot_d;
            phase_q <= phase_d;
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign dot_signal = dot_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fnd_scan_ctrl
// Directed self-checking bench for fnd_scan_ctrl with CLK_FREQ=1000,
// SCAN_HZ=100, DOT_HZ=10 (SCAN_DIV=10, BLINK_DIV=50). Edge k counts rising
// clock edges after reset release; outputs are sampled 1 time unit after
// each edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fnd_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scan_en = 1'b1;
    logic       blink_en = 1'b1;
`ifdef FND_DIM_EN
    logic [1:0] dim_level = 2'd3;
`endif
    logic [2:0] sel;
    logic [3:0] an;
    logic [3:0] dot_signal;
    logic       scan_tick;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fnd_scan_ctrl #(
        .CLK_FREQ (1000),
        .SCAN_HZ  (100),
        .DOT_HZ   (10)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scan_en    (scan_en),
        .blink_en   (blink_en),
`ifdef FND_DIM_EN
        .dim_level  (dim_level),
`endif
        .sel        (sel),
        .an         (an),
        .dot_signal (dot_signal),
        .scan_tick  (scan_tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at edge 0: reset just released, next edge is edge 1.
    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        scan_en  = 1'b1;
        blink_en = 1'b1;
        reset_n  = 1'b0;
        repeat (5) step();
        n_checks++;
        if (sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        n_checks++;
        if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an got=%b exp=1111", an); end
        n_checks++;
        if (dot_signal !== 4'hF) begin n_fail++; $display("FAIL reset_dot got=%h exp=f", dot_signal); end
        n_checks++;
        if (scan_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", scan_tick); end
        reset_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 8) begin
                n_checks++;
                if (scan_tick !== 1'b0) begin n_fail++; $display("FAIL first_tick_early k=%0d got=%b exp=0", k, scan_tick); end
            end
            if (k == 9) begin
                n_checks++;
                if (scan_tick !== 1'b1) begin n_fail++; $display("FAIL first_tick k=%0d got=%b exp=1", k, scan_tick); end
                n_checks++;
                if (sel !== 3'd0) begin n_fail++; $display("FAIL first_tick_sel k=%0d got=%0d exp=0", k, sel); end
            end
            if (k >= 10) begin
                n_checks++;
                if (sel !== 3'd1) begin n_fail++; $display("FAIL first_advance_sel k=%0d got=%0d exp=1", k, sel); end
                n_checks++;
                if (scan_tick !== 1'b0) begin n_fail++; $display("FAIL first_advance_tick k=%0d got=%b exp=0", k, scan_tick); end
            end
        end
        $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_rotation();
        logic [3:0] an_tbl [8];
        logic [2:0] exp_sel;
        logic       exp_tick;
        int         ticks;
        an_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b1111, 4'b1011, 4'b1111};
        ticks  = 0;
        scan_en = 1'b1;
        apply_reset();
        for (int k = 1; k <= 80; k++) begin
            step();
            exp_sel  = 3'((k / 10) % 8);
            exp_tick = ((k % 10) == 9);
            if (scan_tick === 1'b1) ticks++;
            n_checks++;
            if (sel !== exp_sel) begin n_fail++; $display("FAIL rot_sel k=%0d got=%0d exp=%0d", k, sel, exp_sel); end
            n_checks++;
            if (an !== an_tbl[exp_sel]) begin n_fail++; $display("FAIL rot_an k=%0d got=%b exp=%b", k, an, an_tbl[exp_sel]); end
            n_checks++;
            if (scan_tick !== exp_tick) begin n_fail++; $display("FAIL rot_tick k=%0d got=%b exp=%b", k, scan_tick, exp_tick); end
        end
        n_checks++;
        if (ticks != 8) begin n_fail++; $display("FAIL rot_tick_count got=%0d exp=8", ticks); end
        $display("test_rotation done: ticks=%0d final_sel=%0d", ticks, sel);
    endtask

    task automatic test_hold();
        scan_en = 1'b1;
        apply_reset();
        repeat (23) step();          // edge 23: slot 2, prescaler 3
        scan_en = 1'b0;
        for (int k = 24; k <= 48; k++) begin
            step();
            n_checks++;
            if (sel !== 3'd2) begin n_fail++; $display("FAIL hold_sel k=%0d got=%0d exp=2", k, sel); end
            n_checks++;
            if (an !== 4'b1111) begin n_fail++; $display("FAIL hold_an k=%0d got=%b exp=1111", k, an); end
            n_checks++;
            if (scan_tick !== 1'b0) begin n_fail++; $display("FAIL hold_tick k=%0d got=%b exp=0", k, scan_tick); end
        end
        scan_en = 1'b1;
        // Prescaler resumes from 3: counts 4..9 on edges 49..54, advance at 55.
        for (int k = 49; k <= 55; k++) begin
            step();
            if (k <= 54) begin
                n_checks++;
                if (sel !== 3'd2) begin n_fail++; $display("FAIL resume_sel k=%0d got=%0d exp=2", k, sel); end
                n_checks++;
                if (an !== 4'b1011) begin n_fail++; $display("FAIL resume_an k=%0d got=%b exp=1011", k, an); end
                n_checks++;
                if (scan_tick !== (k == 54)) begin n_fail++; $display("FAIL resume_tick k=%0d got=%b exp=%b", k, scan_tick, (k == 54)); end
            end else begin
                n_checks++;
                if (sel !== 3'd3) begin n_fail++; $display("FAIL resume_advance k=%0d got=%0d exp=3", k, sel); end
            end
        end
        $display("test_hold done: sel=%0d an=%b", sel, an);
    endtask

    task automatic test_blink();
        logic [3:0] exp_dot;
        logic [3:0] prev_dot;
        logic       prev_tick;
        scan_en  = 1'b1;
        blink_en = 1'b1;
        apply_reset();
        prev_dot  = dot_signal;
        prev_tick = scan_tick;
        for (int k = 1; k <= 200; k++) begin
            step();
            exp_dot = (((k / 50) % 2) == 1) ? 4'hE : 4'hF;
            n_checks++;
            if (dot_signal !== exp_dot) begin n_fail++; $display("FAIL blink_dot k=%0d got=%h exp=%h", k, dot_signal, exp_dot); end
            n_checks++;
            if ((dot_signal !== prev_dot) && (prev_tick !== 1'b1)) begin
                n_fail++; $display("FAIL blink_midslot k=%0d got=%h exp=%h", k, dot_signal, prev_dot);
            end
            prev_dot  = dot_signal;
            prev_tick = scan_tick;
        end
        // Phase is 0 here; disabling blink must light the dot only at edge 210.
        for (int k = 201; k <= 210; k++) begin
            step();
            exp_dot = (k >= 210) ? 4'hE : 4'hF;
            n_checks++;
            if (dot_signal !== exp_dot) begin n_fail++; $display("FAIL blink_off k=%0d got=%h exp=%h", k, dot_signal, exp_dot); end
            if (k == 205) blink_en = 1'b0;
        end
        blink_en = 1'b1;
        $display("test_blink done: dot=%h", dot_signal);
    endtask

    task automatic test_async_reset();
        scan_en  = 1'b1;
        blink_en = 1'b1;
        apply_reset();
        repeat (63) step();          // slot 6, dot lit since edge 50
        n_checks++;
        if (sel !== 3'd6) begin n_fail++; $display("FAIL pre_async_sel got=%0d exp=6", sel); end
        n_checks++;
        if (an !== 4'b1011) begin n_fail++; $display("FAIL pre_async_an got=%b exp=1011", an); end
        n_checks++;
        if (dot_signal !== 4'hE) begin n_fail++; $display("FAIL pre_async_dot got=%h exp=e", dot_signal); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (sel !== 3'd0) begin n_fail++; $display("FAIL async_sel got=%0d exp=0", sel); end
        n_checks++;
        if (an !== 4'b1111) begin n_fail++; $display("FAIL async_an got=%b exp=1111", an); end
        n_checks++;
        if (dot_signal !== 4'hF) begin n_fail++; $display("FAIL async_dot got=%h exp=f", dot_signal); end
        n_checks++;
        if (scan_tick !== 1'b0) begin n_fail++; $display("FAIL async_tick got=%b exp=0", scan_tick); end
        step();
        reset_n = 1'b1;
        $display("test_async_reset done: sel=%0d an=%b dot=%h", sel, an, dot_signal);
    endtask

`ifdef FND_DIM_EN
    task automatic test_dim();
        logic [3:0] exp_an;
        scan_en   = 1'b1;
        dim_level = 2'd1;
        apply_reset();
        repeat (79) step();
        for (int k = 80; k <= 89; k++) begin
            step();
            exp_an = ((k - 80) < 5) ? 4'b1110 : 4'b1111;
            n_checks++;
            if (an !== exp_an) begin n_fail++; $display("FAIL dim1_an k=%0d got=%b exp=%b", k, an, exp_an); end
        end
        dim_level = 2'd3;
        repeat (70) step();
        for (int k = 160; k <= 169; k++) begin
            step();
            n_checks++;
            if (an !== 4'b1110) begin n_fail++; $display("FAIL dim3_an k=%0d got=%b exp=1110", k, an); end
        end
        $display("test_dim done: an=%b", an);
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_hold();
        test_blink();
        test_async_reset();
`ifdef FND_DIM_EN
        test_dim();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
